// File: rtl/ysyx_22041405_pkg.sv
// Shared definitions for the instruction fetch unit: reset vector,
// FSM state encoding and the canonical NOP used for bubble insertion.
package ysyx_22041405_pkg;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22041405_ifu_if.sv
// Fetch-side bus: instruction-memory request/response plus the IFU-to-IDU
// valid/ready channel. master is the IFU, slave is memory + decoder.
interface ysyx_22041405_ifu_if #(
  parameter int WIDTH = 32
);
  import ysyx_22041405_pkg::*;

  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_resp_valid;
  logic [WIDTH-1:0] imem_resp_data;
  logic             if_valid;
  logic             if_ready;
  logic [WIDTH-1:0] if_instr;
  logic [WIDTH-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
  );

endinterface

// File: rtl/ysyx_22041405_pc_reg.sv
// Program counter: sequential +4 advance with a word-aligned redirect
// override that always wins.
module ysyx_22041405_pc_reg #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = ysyx_22041405_pkg::RESET_PC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_inc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] pc
);
  import ysyx_22041405_pkg::*;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~WIDTH'(3);
    end else if (pc_inc) begin
      pc <= pc + WIDTH'(4);
    end
  end

endmodule

// File: rtl/ysyx_22041405_ifu.sv
// Instruction fetch unit: one outstanding imem read, single-entry buffer,
// valid/ready hand-off to the IDU, redirect squashes in-flight or held work.
//
//   state  | meaning
//   S_REQ  | imem request presented at pc, waiting for acceptance
//   S_WAIT | request accepted, waiting for the response word
//   S_OUT  | instruction held and offered to the IDU
module ysyx_22041405_ifu #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = ysyx_22041405_pkg::RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect_valid,
  input  logic [WIDTH-1:0]           redirect_pc,
  ysyx_22041405_ifu_if.master        bus
);
  import ysyx_22041405_pkg::*;

  ifu_state_e       state;
  logic             drop;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc;
  logic             pc_inc;

  assign pc_inc = (state == S_OUT) && bus.if_ready && !redirect_valid;

  ysyx_22041405_pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_inc         (pc_inc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_REQ;
      drop    <= 1'b0;
      instr_q <= '0;
    end else begin
      case (state)
        S_REQ: begin
          // a redirect racing an accepted request leaves a stale response to eat
          if (bus.imem_req_ready) begin
            state <= S_WAIT;
            if (redirect_valid) drop <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            if (redirect_valid || drop) begin
              state <= S_REQ;
              drop  <= 1'b0;
            end else begin
              instr_q <= bus.imem_resp_data;
              state   <= S_OUT;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        S_OUT: begin
          if (redirect_valid || bus.if_ready) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign bus.imem_req_valid = (state == S_REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = (state == S_OUT);
  assign bus.if_instr       = instr_q;
  assign bus.if_pc          = pc;

endmodule
